vga_pixel_feeder: RTL

Upstream stage of the VGA timing generator. It walks a linear framebuffer region in raster order and issues read requests to pixel memory. Returned pixels are buffered in a first-word-fall-through FIFO, which the timing generator drains through its rd_fifo strobe. The block drives the generator's done (prefill complete) and empty inputs, so the raster counters only advance once pixel data is guaranteed present.

---
 rtl/vga_pixel_feeder_if.sv | 37 +++
 rtl/vga_pixel_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_feeder_if.sv
// vga_pixel_feeder_if: pixel-memory read bus plus the FWFT pixel
// port toward the VGA timing generator.
interface vga_pixel_feeder_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 19
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              rd_fifo;
    logic [DATA_W-1:0] pixel_data;
    logic              empty;
    logic              done;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        input  mem_rvalid,
        input  rd_fifo,
        output pixel_data,
        output empty,
        output done
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        output mem_rvalid,
        output rd_fifo,
        input  pixel_data,
        input  empty,
        input  done
    );
endinterface

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: walks the framebuffer in raster order, buffers pixels
// in a FWFT FIFO. Define VGA_FEEDER_UNDERRUN_CNT_EN for underrun_cnt.
module vga_pixel_feeder #(
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 19,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PREFILL  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    vga_pixel_feeder_if.master bus,
    output logic               frame_start,
    output logic               overflow,
    output logic               underflow
`ifdef VGA_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] storage [DEPTH];
    logic [CW:0]       inflight;

    logic credit;
    logic req;
    logic flush;
    logic full;
    logic empty_i;
    logic push;
    logic pop;
    logic rsp;

    assign full     = (count == DEPTH_C);
    assign empty_i  = (count == '0);
    assign push     = bus.mem_rvalid && !full && !flush;
    assign pop      = bus.rd_fifo && !empty_i && !flush;
    assign rsp      = bus.mem_rvalid && (outstanding != '0);
    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign credit   = inflight < DEPTH_X;

    assign bus.empty      = empty_i;
    assign bus.done       = (state == S_STREAM);
    assign bus.pixel_data = empty_i ? '0 : storage[rd_ptr];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state, request permission and end-of-drain flush
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        flush     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_PREFILL;
            end
            S_PREFILL: begin
                req = enable && credit;
                if (!enable)
                    state_nxt = S_DRAIN;
                else if (count >= PREFILL_C)
                    state_nxt = S_STREAM;
            end
            S_STREAM: begin
                req = enable && credit;
                if (!enable) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request issue, raster address walk and frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            frame_start   <= 1'b0;
            addr          <= '0;
        end else begin
            bus.mem_rd_en <= req;
            frame_start   <= req && (addr == '0);
            if (req) begin
                bus.mem_addr <= addr;
                addr <= (addr == LAST) ? '0 : addr + ADDR_W'(1);
            end else if (flush) begin
                addr <= '0;
            end
        end
    end

    // Reads in flight, used as FIFO credit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            unique case ({req, rsp})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= bus.mem_rdata;
    end

    // Sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.mem_rvalid && full) overflow <= 1'b1;
            if (bus.rd_fifo && empty_i) underflow <= 1'b1;
        end
    end

`ifdef VGA_FEEDER_UNDERRUN_CNT_EN
    // Saturating count of STREAM cycles with no pixel ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun_cnt <= '0;
        else if (flush)
            underrun_cnt <= '0;
        else if (state == S_STREAM && empty_i && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule
